// File: rtl/fetch_queue_if.sv
// Bundle between the PC controller / instruction memory, the fetch queue and decode.
// master drives fetch/dequeue controls; slave is the queue itself.
interface fetch_queue_if #(
  parameter int branch_addr = 4,
  parameter int inst_width  = 32,
  parameter int depth       = 8
);
  localparam int CW = $clog2(depth) + 1;

  logic                   flush;
  logic                   fetch_en;
  logic [branch_addr-1:0] pc;
  logic [branch_addr-1:0] imem_addr;
  logic [inst_width-1:0]  imem_data0;
  logic [inst_width-1:0]  imem_data1;
  logic                   deq_ready;
  logic                   deq_valid;
  logic [inst_width-1:0]  deq_inst;
  logic [branch_addr-1:0] deq_pc;
  logic                   iq_full;
  logic                   iq_empty;
  logic [CW-1:0]          iq_count;
  logic                   ovf_err;

  modport master (
    output flush, fetch_en, pc, imem_data0, imem_data1, deq_ready,
    input  imem_addr, deq_valid, deq_inst, deq_pc, iq_full, iq_empty, iq_count, ovf_err
  );

  modport slave (
    input  flush, fetch_en, pc, imem_data0, imem_data1, deq_ready,
    output imem_addr, deq_valid, deq_inst, deq_pc, iq_full, iq_empty, iq_count, ovf_err
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue: accepts an instruction pair per fetch cycle,
// hands one instruction per cycle to decode, and back-pressures fetch via iq_full.
module fetch_queue #(
  parameter int branch_addr = 4,
  parameter int inst_width  = 32,
  parameter int depth       = 8
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.slave fq
);
  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;

  logic [inst_width-1:0]  r_inst [depth];
  logic [branch_addr-1:0] r_pc   [depth];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   r_ovf_err;

  logic                   w_full;
  logic                   w_valid;
  logic                   w_push;
  logic                   w_pop;
  logic [PW-1:0]          w_wr_ptr1;
  logic [branch_addr-1:0] w_pc4;
  logic [CW-1:0]          w_count_next;

  // Full means fewer than two free slots, so a whole pair always fits when not full.
  assign w_full       = (r_count > CW'(depth - 2));
  assign w_valid      = (r_count != '0);
  assign w_push       = fq.fetch_en & ~w_full & ~fq.flush;
  assign w_pop        = w_valid & fq.deq_ready & ~fq.flush;
  assign w_wr_ptr1    = r_wr_ptr + PW'(1);
  assign w_pc4        = fq.pc + branch_addr'(4);
  assign w_count_next = r_count + (w_push ? CW'(2) : CW'(0)) - (w_pop ? CW'(1) : CW'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      if (fq.fetch_en && w_full) begin
        r_ovf_err <= 1'b1;
      end
      if (fq.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(2);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= w_count_next;
      end
    end
  end

  // Storage is never reset; validity is tracked only by the count.
  for (genvar gi = 0; gi < depth; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (w_push && (r_wr_ptr == PW'(gi))) begin
        r_inst[gi] <= fq.imem_data0;
        r_pc[gi]   <= fq.pc;
      end else if (w_push && (w_wr_ptr1 == PW'(gi))) begin
        r_inst[gi] <= fq.imem_data1;
        r_pc[gi]   <= w_pc4;
      end
    end
  end

  assign fq.imem_addr = fq.pc;
  assign fq.deq_valid = w_valid;
  assign fq.deq_inst  = r_inst[r_rd_ptr];
  assign fq.deq_pc    = r_pc[r_rd_ptr];
  assign fq.iq_full   = w_full;
  assign fq.iq_empty  = ~w_valid;
  assign fq.iq_count  = r_count;
  assign fq.ovf_err   = r_ovf_err;
endmodule
